// File: rtl/gcd_lcm_responder_if.sv
// Start/data/answer channel between the processor (master) and the
// GCD/LCM coprocessor (slave). The processor drives operands and the
// function select; the coprocessor returns its result and status flags.
interface gcd_lcm_responder_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] wd;
   logic             func;
   logic [WIDTH-1:0] ans_data;
   logic             busy;
   logic             done;
   logic             ovf;

   modport master (
      output start, wd, func,
      input  ans_data, busy, done, ovf
   );

   modport slave (
      input  start, wd, func,
      output ans_data, busy, done, ovf
   );
endinterface

// File: rtl/gcd_lcm_responder.sv
// GCD/LCM coprocessor, responder side of the start/data/answer channel.
// Operand A arrives with the first start strobe, operand B and the function
// select with the second. GCD is found with the binary (Stein) method one step
// per cycle. LCM is formed as (A/g)*B using a restoring divider followed by a
// shift-add multiplier. The result register only changes in FINISH or reset.
module gcd_lcm_responder #(
   parameter int WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   gcd_lcm_responder_if.slave        bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      IDLE, WAIT_B, GCD_NORM, GCD_LOOP, DIV, MUL, FINISH
   } state_t;

   state_t             state, state_n;
   logic [WIDTH-1:0]   a_r, a_n, b_r, b_n;
   logic [WIDTH-1:0]   wa, wa_n, wb, wb_n;
   logic [WIDTH-1:0]   g_r, g_n, lcm_r, lcm_n, ans_r, ans_n;
   logic [WIDTH-1:0]   dq, dq_n, rem, rem_n;
   logic [2*WIDTH-1:0] acc, acc_n;
   logic [5:0]         k, k_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic               fsel, fsel_n, busy_r, busy_n, done_r, done_n, ovf_r, ovf_n;
   logic [WIDTH:0]     rem_s, sum;

   assign bus.ans_data = ans_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.ovf      = ovf_r;

   // State and datapath registers; reset clears everything so an aborted
   // operation leaves no partial result behind.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         wa     <= '0;
         wb     <= '0;
         g_r    <= '0;
         lcm_r  <= '0;
         ans_r  <= '0;
         dq     <= '0;
         rem    <= '0;
         acc    <= '0;
         k      <= '0;
         cnt    <= '0;
         fsel   <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         state  <= state_n;
         a_r    <= a_n;
         b_r    <= b_n;
         wa     <= wa_n;
         wb     <= wb_n;
         g_r    <= g_n;
         lcm_r  <= lcm_n;
         ans_r  <= ans_n;
         dq     <= dq_n;
         rem    <= rem_n;
         acc    <= acc_n;
         k      <= k_n;
         cnt    <= cnt_n;
         fsel   <= fsel_n;
         busy_r <= busy_n;
         done_r <= done_n;
         ovf_r  <= ovf_n;
      end
   end

   // Next-state and datapath step for each phase of the computation.
   always_comb begin
      state_n = state;
      a_n     = a_r;
      b_n     = b_r;
      wa_n    = wa;
      wb_n    = wb;
      g_n     = g_r;
      lcm_n   = lcm_r;
      ans_n   = ans_r;
      dq_n    = dq;
      rem_n   = rem;
      acc_n   = acc;
      k_n     = k;
      cnt_n   = cnt;
      fsel_n  = fsel;
      busy_n  = busy_r;
      done_n  = done_r;
      ovf_n   = ovf_r;
      rem_s   = {rem, dq[WIDTH-1]};
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);

      case (state)
         IDLE: begin
            if (bus.start) begin
               a_n     = bus.wd;
               done_n  = 1'b0;
               ovf_n   = 1'b0;
               state_n = WAIT_B;
            end
         end
         WAIT_B: begin
            if (bus.start) begin
               b_n     = bus.wd;
               fsel_n  = bus.func;
               busy_n  = 1'b1;
               wa_n    = a_r;
               wb_n    = bus.wd;
               k_n     = '0;
               state_n = GCD_NORM;
            end
         end
         GCD_NORM: begin
            if (wa == '0 || wb == '0) begin
               g_n     = wa | wb;
               lcm_n   = '0;
               state_n = FINISH;
            end else if (!wa[0] && !wb[0]) begin
               wa_n = wa >> 1;
               wb_n = wb >> 1;
               k_n  = k + 6'd1;
            end else begin
               state_n = GCD_LOOP;
            end
         end
         GCD_LOOP: begin
            if (wb == '0) begin
               g_n = wa << k;
               if (fsel) begin
                  dq_n    = a_r;
                  rem_n   = '0;
                  cnt_n   = '0;
                  state_n = DIV;
               end else begin
                  state_n = FINISH;
               end
            end else if (!wa[0]) begin
               wa_n = wa >> 1;
            end else if (!wb[0]) begin
               wb_n = wb >> 1;
            end else if (wa > wb) begin
               wa_n = wb;
               wb_n = wa;
            end else begin
               wb_n = wb - wa;
            end
         end
         DIV: begin
            if (rem_s >= {1'b0, g_r}) begin
               rem_n = rem_s[WIDTH-1:0] - g_r;
               dq_n  = {dq[WIDTH-2:0], 1'b1};
            end else begin
               rem_n = rem_s[WIDTH-1:0];
               dq_n  = {dq[WIDTH-2:0], 1'b0};
            end
            if (cnt == CW'(WIDTH-1)) begin
               acc_n   = {{WIDTH{1'b0}}, dq_n};
               cnt_n   = '0;
               state_n = MUL;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         MUL: begin
            acc_n = {sum, acc[WIDTH-1:1]};
            if (cnt == CW'(WIDTH-1)) begin
               ovf_n   = |acc_n[2*WIDTH-1:WIDTH];
               lcm_n   = acc_n[WIDTH-1:0];
               state_n = FINISH;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         FINISH: begin
            ans_n   = fsel ? lcm_r : g_r;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_gcd_lcm_responder.sv
// Directed bench for the GCD/LCM coprocessor. Expected results come from a
// Euclid-based reference model, are queued when operand B is issued and are
// popped when done rises.
module tb_gcd_lcm_responder;

   localparam int WIDTH = 32;

   typedef struct {
      logic [WIDTH-1:0] ans;
      logic             ovf;
   } exp_t;

   logic clk;
   logic reset;
   exp_t sb[$];
   int   check_count = 0;
   int   pass_count  = 0;
   int   lat;

   gcd_lcm_responder_if #(.WIDTH(WIDTH)) bus ();

   gcd_lcm_responder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] model_gcd(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic exp_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic f);
      exp_t             e;
      logic [WIDTH-1:0] g;
      logic [63:0]      p;
      g = model_gcd(a, b);
      if (a == 0 || b == 0) p = 64'd0;
      else                  p = 64'(a / g) * 64'(b);
      e.ans = f ? p[WIDTH-1:0] : g;
      e.ovf = f ? (p[63:WIDTH] != 0) : 1'b0;
      return e;
   endfunction

   task automatic check_val(string tag, logic [63:0] obs, logic [63:0] exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic send_a(logic [WIDTH-1:0] a);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.wd    = a;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic send_b(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic f);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.wd    = b;
      bus.func  = f;
      sb.push_back(model(a, b, f));
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic apply_stimulus(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic f);
      send_a(a);
      send_b(a, b, f);
   endtask

   task automatic check_output(string tag, int bound, output int latency);
      int   cycles;
      exp_t e;
      cycles = 0;
      while (bus.done !== 1'b1 && cycles < bound) begin
         @(posedge clk); #1;
         cycles++;
      end
      latency = cycles + 1;
      check_val({tag, "_done"}, 64'(bus.done), 64'd1);
      if (sb.size() != 0) e = sb.pop_front();
      else begin
         e.ans = 'x;
         e.ovf = 1'bx;
      end
      check_val({tag, "_ans"}, 64'(bus.ans_data), 64'(e.ans));
      check_val({tag, "_ovf"}, 64'(bus.ovf), 64'(e.ovf));
      check_val({tag, "_busy"}, 64'(bus.busy), 64'd0);
   endtask

   // Linear sequence of directed transactions.
   initial begin
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.wd    = '0;
      bus.func  = 1'b0;
      #2;
      check_val("rst_ans", 64'(bus.ans_data), 64'd0);
      check_val("rst_busy", 64'(bus.busy), 64'd0);
      check_val("rst_done", 64'(bus.done), 64'd0);
      check_val("rst_ovf", 64'(bus.ovf), 64'd0);
      #21 reset = 1'b1;

      // Basic GCD with latency bound.
      apply_stimulus(32'd48, 32'd18, 1'b0);
      check_output("gcd_48_18", 4*WIDTH+8, lat);
      check_val("gcd_48_18_latency", 64'(lat <= 4*WIDTH+8), 64'd1);

      // New A without B: result held, no activity.
      send_a(32'd10);
      repeat (50) @(posedge clk);
      #1;
      check_val("hold_ans", 64'(bus.ans_data), 64'd6);
      check_val("hold_done", 64'(bus.done), 64'd0);
      check_val("hold_busy", 64'(bus.busy), 64'd0);
      send_b(32'd10, 32'd4, 1'b0);
      check_output("gcd_10_4", 400, lat);

      // LCM, then back-to-back overflow case.
      apply_stimulus(32'd21, 32'd6, 1'b1);
      check_output("lcm_21_6", 400, lat);
      apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
      check_output("lcm_ovf", 600, lat);

      // Zero and identical operands.
      apply_stimulus(32'd0, 32'd35, 1'b0);
      check_output("gcd_zero", 400, lat);
      apply_stimulus(32'd0, 32'd35, 1'b1);
      check_output("lcm_zero", 400, lat);
      apply_stimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
      check_output("gcd_k31", 400, lat);

      // Strobe while busy must be ignored.
      apply_stimulus(32'd12, 32'd8, 1'b0);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.wd    = 32'd99;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_val("ign_busy", 64'(bus.busy), 64'd1);
      check_val("ign_done", 64'(bus.done), 64'd0);
      check_output("gcd_12_8", 400, lat);
      repeat (3) @(posedge clk);
      #1;
      check_val("ign_idle_busy", 64'(bus.busy), 64'd0);
      check_val("ign_idle_done", 64'(bus.done), 64'd1);
      apply_stimulus(32'd5, 32'd10, 1'b0);
      check_output("gcd_5_10", 400, lat);

      // Asynchronous reset in the middle of the GCD loop.
      apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      repeat (10) @(posedge clk);
      #4 reset = 1'b0;
      #1;
      check_val("abort_ans", 64'(bus.ans_data), 64'd0);
      check_val("abort_busy", 64'(bus.busy), 64'd0);
      check_val("abort_done", 64'(bus.done), 64'd0);
      check_val("abort_ovf", 64'(bus.ovf), 64'd0);
      // The aborted operation never completes, so drop its expectation.
      if (sb.size() != 0) sb.pop_back();
      #12 reset = 1'b1;
      apply_stimulus(32'd7, 32'd5, 1'b1);
      check_output("lcm_7_5", 400, lat);

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/gcd_lcm_responder.md
Name: gcd_lcm_responder

Overview:
- Responder end of the processor-to-coprocessor Start/data/answer interface.
- The processor pulses start twice, presenting operand A and then operand B on wd. The block then computes GCD(A,B) with a binary (Stein) GCD and LCM(A,B) with a sequential divider and multiplier.
- It returns the function selected with operand B on ans_data and flags completion on done.
- It sits beside the single-cycle core and dmem at the top level and is driven from the same store-data path.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle operand strobe from the core.
- wd  input  WIDTH  operand data; sampled only when start=1.
- func  input  1  result select, sampled with operand B: 0=GCD, 1=LCM.
- ans_data  output  WIDTH  result register.
- busy  output  1  high while an operation is computing.
- done  output  1  high from result-valid until the next accepted start.
- ovf  output  1  LCM result exceeded WIDTH bits (valid when done=1).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - ans_data=0, busy=0, done=0, ovf=0.
  - All internal operand, shift-count and accumulator registers cleared.
  - Reset mid-computation aborts the operation with no partial result visible.
- States: IDLE, WAIT_B, GCD_NORM, GCD_LOOP, DIV, MUL, FINISH.
- IDLE: start=1 latches A=wd, clears done and ovf, goes to WAIT_B.
- WAIT_B: start=1 latches B=wd and func, sets busy=1, goes to GCD_NORM. Without start the block waits indefinitely.
- Start handling in other states:
  - In DONE/IDLE, start is a new A (done drops the cycle after).
  - start while busy=1 is ignored; no queuing.
- Zero operands: checked on entry to GCD_NORM.
  - If A=0 or B=0: g=A|B, lcm=0, go directly to FINISH.
- GCD_NORM: one step per cycle.
  - While both working values are even, shift both right by 1 and increment k (k is 6 bits wide).
  - Then go to GCD_LOOP.
- GCD_LOOP: one action per cycle, in priority order:
  1. If a is even, shift a right by 1.
  2. Else if b is even, shift b right by 1.
  3. Else if a>b, swap a and b.
  4. Else b=b-a.
  - When b=0: g=a<<k.
  - If func=0, go to FINISH; else go to DIV.
- DIV: restoring shift-subtract division q=A/g, WIDTH cycles, exact (the remainder is always 0).
- MUL: shift-add multiply of q*B, WIDTH cycles, with a 2*WIDTH accumulator.
  - ovf = (upper WIDTH bits != 0).
  - lcm = lower WIDTH bits.
- FINISH (1 cycle): ans_data = (func ? lcm : g); busy=0; done=1; go to IDLE.
- ans_data changes only in FINISH or on reset. It holds the last result through the next transaction.
- Latency bound from start(B) to done=1: ≤ 4*WIDTH+8 cycles for GCD, plus 2*WIDTH for LCM.
- All arithmetic is unsigned. Operands are treated as unsigned WIDTH-bit values.

Test Plan:
- Basic GCD: reset → start wd=48, then start wd=18 with func=0 → done=1 within 136 cycles, ans_data=6, ovf=0, busy low once done.
- LCM: A=21, B=6, func=1 → ans_data=42, ovf=0. Back-to-back with a new A=0xFFFFFFFF, B=0xFFFFFFFE, func=1 → ans_data=0x00000002 (lower bits of 0xFFFFFFFD00000002), ovf=1.
- Zero and identical operands:
  - A=0, B=35, func=0 → 35.
  - Same with func=1 → 0.
  - A=B=0x80000000, func=0 → 0x80000000 (k=31 path).
- start pulsed with wd=99 while busy: the result of A=12, B=8, func=0 is still 4. done stays 0 until completion. The ignored strobe is not latched as the next A.
- Reset asserted asynchronously mid-GCD_LOOP: outputs go to 0 immediately, without waiting for a clock edge. After release, a new A=7, B=5, func=1 → ans_data=35.
- Hold check: after ans_data=6, issue start(A=10) and wait 50 cycles with no B → ans_data stays 6, done=0, busy=0.
